// File: rtl/credit_flow_governor_pkg.sv
// Shared types and default sizing for the credit flow governor and its per-channel trackers.
package credit_flow_governor_pkg;

  localparam int num_ch   = 2;
  localparam int ch_depth = 16;

  typedef enum logic {OPEN, THROTTLED} ch_state_t;
  typedef enum logic [1:0] {RUN, DRAIN, DRAINED} drain_state_t;

endpackage

// File: rtl/credit_flow_governor_channel.sv
// One channel's outstanding-request counter with stop hysteresis, peak watermark and sticky errors.
module credit_channel
  import credit_flow_governor_pkg::*;
#(
  parameter int DEPTH         = ch_depth,
  parameter int STOP_MARGIN   = 1,
  parameter int RESUME_MARGIN = 3,
  parameter int CNT_W         = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             clr_peak_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] cnt_next_o,
  output logic [CNT_W-1:0] peak_o,
  output logic             throttled_o,
  output logic             err_ovf_o,
  output logic             err_unf_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] STOP_TH = CNT_W'(DEPTH - STOP_MARGIN);
  localparam logic [CNT_W-1:0] RES_TH  = CNT_W'(DEPTH - RESUME_MARGIN);

  logic [CNT_W-1:0] cnt_q, cnt_d, peak_q, peak_d;
  ch_state_t        st_q, st_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    // Simultaneous issue and completion cancel out and leave the count alone.
    if (inc_i && !dec_i) begin
      if (cnt_q == CNT_MAX) ovf_d = 1'b1;
      else                  cnt_d = cnt_q + CNT_W'(1);
    end else if (dec_i && !inc_i) begin
      if (cnt_q == '0) unf_d = 1'b1;
      else             cnt_d = cnt_q - CNT_W'(1);
    end

    st_d = st_q;
    if (st_q == OPEN) begin
      if (cnt_d >= STOP_TH) st_d = THROTTLED;
    end else if (cnt_d <= RES_TH) begin
      st_d = OPEN;
    end

    if (clr_peak_i)          peak_d = cnt_d;
    else if (cnt_d > peak_q) peak_d = cnt_d;
    else                     peak_d = peak_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      peak_q <= '0;
      st_q   <= OPEN;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      peak_q <= peak_d;
      st_q   <= st_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  assign cnt_o       = cnt_q;
  assign cnt_next_o  = cnt_d;
  assign peak_o      = peak_q;
  assign throttled_o = (st_q == THROTTLED);
  assign err_ovf_o   = ovf_q;
  assign err_unf_o   = unf_q;

endmodule

// File: rtl/credit_flow_governor.sv
// Per-channel outstanding-request governor: issue decode, channel array, global drain FSM, output packing.
module credit_flow_governor
  import credit_flow_governor_pkg::*;
#(
  parameter  int NUM_CH        = num_ch,
  parameter  int DEPTH         = ch_depth,
  parameter  int STOP_MARGIN   = 1,
  parameter  int RESUME_MARGIN = 3,
  localparam int CNT_W         = $clog2(DEPTH + 1),
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    issue_valid_i,
  input  logic [CH_W-1:0]         issue_ch_i,
  input  logic [NUM_CH-1:0]       done_i,
  input  logic                    drain_req_i,
  input  logic                    clr_peak_i,
  output logic [NUM_CH-1:0]       stop_o,
  output logic [NUM_CH*CNT_W-1:0] occupancy_o,
  output logic [NUM_CH*CNT_W-1:0] peak_o,
  output logic [NUM_CH-1:0]       err_overflow_o,
  output logic [NUM_CH-1:0]       err_underflow_o,
  output logic                    drain_done_o
);

  if (RESUME_MARGIN <= STOP_MARGIN) begin : g_bad_margins
    $error("RESUME_MARGIN must exceed STOP_MARGIN");
  end

  logic [NUM_CH-1:0]            inc, thr;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt, cnt_nxt, pk;
  logic                         all_zero;

  // Channel ids beyond NUM_CH match no comparator and are dropped.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign inc[c] = issue_valid_i && (issue_ch_i == CH_W'(c));

    credit_channel #(
      .DEPTH        (DEPTH),
      .STOP_MARGIN  (STOP_MARGIN),
      .RESUME_MARGIN(RESUME_MARGIN),
      .CNT_W        (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .inc_i      (inc[c]),
      .dec_i      (done_i[c]),
      .clr_peak_i (clr_peak_i),
      .cnt_o      (cnt[c]),
      .cnt_next_o (cnt_nxt[c]),
      .peak_o     (pk[c]),
      .throttled_o(thr[c]),
      .err_ovf_o  (err_overflow_o[c]),
      .err_unf_o  (err_underflow_o[c])
    );
  end

  assign all_zero = (cnt_nxt == '0);

  drain_state_t ds_q;
  logic         blk_q, dd_q;

  // blk_q / dd_q track the state being entered so they line up with occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ds_q  <= RUN;
      blk_q <= 1'b0;
      dd_q  <= 1'b0;
    end else begin
      case (ds_q)
        RUN: if (drain_req_i) begin
          ds_q  <= DRAIN;
          blk_q <= 1'b1;
        end
        DRAIN: if (!drain_req_i) begin
          ds_q  <= RUN;
          blk_q <= 1'b0;
        end else if (all_zero) begin
          ds_q <= DRAINED;
          dd_q <= 1'b1;
        end
        DRAINED: if (!drain_req_i) begin
          ds_q  <= RUN;
          blk_q <= 1'b0;
          dd_q  <= 1'b0;
        end else if (!all_zero) begin
          ds_q <= DRAIN;
          dd_q <= 1'b0;
        end
        default: begin
          ds_q  <= RUN;
          blk_q <= 1'b0;
          dd_q  <= 1'b0;
        end
      endcase
    end
  end

  assign stop_o       = thr | {NUM_CH{blk_q}};
  assign occupancy_o  = cnt;
  assign peak_o       = pk;
  assign drain_done_o = dd_q;

endmodule

// File: tb/tb_credit_flow_governor.sv
// Directed bench for credit_flow_governor (2 channels, depth 16, margins 1/3) with a scoreboard of expected outputs.
module tb_credit_flow_governor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       issue_valid;
  logic       issue_ch;
  logic [1:0] done;
  logic       drain_req;
  logic       clr_peak;
  logic [1:0] stop;
  logic [9:0] occupancy;
  logic [9:0] peak;
  logic [1:0] err_overflow;
  logic [1:0] err_underflow;
  logic       drain_done;

  credit_flow_governor #(
    .NUM_CH(2), .DEPTH(16), .STOP_MARGIN(1), .RESUME_MARGIN(3)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .issue_valid_i  (issue_valid),
    .issue_ch_i     (issue_ch),
    .done_i         (done),
    .drain_req_i    (drain_req),
    .clr_peak_i     (clr_peak),
    .stop_o         (stop),
    .occupancy_o    (occupancy),
    .peak_o         (peak),
    .err_overflow_o (err_overflow),
    .err_underflow_o(err_underflow),
    .drain_done_o   (drain_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] stop;
    logic [9:0] occ;
    logic [9:0] peak;
    logic [1:0] ovf;
    logic [1:0] unf;
    logic       dd;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Reference state
  int m_cnt[2], m_peak[2];
  bit m_thr[2], m_ovf[2], m_unf[2];
  int m_ds;  // 0 run, 1 drain, 2 drained

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model(input logic rn, input logic iv, input logic ich,
                       input logic [1:0] dn, input logic dr, input logic cp);
    bit allz = 1'b1;
    if (!rn) begin
      for (int c = 0; c < 2; c++) begin
        m_cnt[c] = 0; m_peak[c] = 0; m_thr[c] = 0; m_ovf[c] = 0; m_unf[c] = 0;
      end
      m_ds = 0;
      return;
    end
    for (int c = 0; c < 2; c++) begin
      bit inc = iv && (int'(ich) == c);
      bit dec = dn[c];
      int n = m_cnt[c];
      if (inc && !dec) begin
        if (n == 16) m_ovf[c] = 1; else n++;
      end else if (dec && !inc) begin
        if (n == 0) m_unf[c] = 1; else n--;
      end
      if (!m_thr[c] && n >= 15) m_thr[c] = 1;
      else if (m_thr[c] && n <= 13) m_thr[c] = 0;
      if (cp || n > m_peak[c]) m_peak[c] = n;
      m_cnt[c] = n;
      if (n != 0) allz = 1'b0;
    end
    case (m_ds)
      0: if (dr) m_ds = 1;
      1: if (!dr) m_ds = 0; else if (allz) m_ds = 2;
      default: if (!dr) m_ds = 0; else if (!allz) m_ds = 1;
    endcase
  endtask

  task automatic step(input logic rn, input logic iv, input logic ich,
                      input logic [1:0] dn, input logic dr, input logic cp);
    exp_t e;
    rst_n = rn; issue_valid = iv; issue_ch = ich; done = dn; drain_req = dr; clr_peak = cp;
    model(rn, iv, ich, dn, dr, cp);
    e.occ  = {5'(m_cnt[1]), 5'(m_cnt[0])};
    e.peak = {5'(m_peak[1]), 5'(m_peak[0])};
    e.stop = {m_thr[1] | (m_ds != 0), m_thr[0] | (m_ds != 0)};
    e.ovf  = {m_ovf[1], m_ovf[0]};
    e.unf  = {m_unf[1], m_unf[0]};
    e.dd   = (m_ds == 2);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("occupancy", 32'(occupancy), 32'(e.occ));
    check("peak", 32'(peak), 32'(e.peak));
    check("stop", 32'(stop), 32'(e.stop));
    check("err_overflow", 32'(err_overflow), 32'(e.ovf));
    check("err_underflow", 32'(err_underflow), 32'(e.unf));
    check("drain_done", 32'(drain_done), 32'(e.dd));
  endtask

  task automatic idle(input int n, input logic dr);
    for (int i = 0; i < n; i++) step(1, 0, 0, 2'b00, dr, 0);
  endtask

  task automatic issue(input int n, input logic ch, input logic dr);
    for (int i = 0; i < n; i++) step(1, 1, ch, 2'b00, dr, 0);
  endtask

  task automatic complete(input int n, input logic [1:0] dn, input logic dr);
    for (int i = 0; i < n; i++) step(1, 0, 0, dn, dr, 0);
  endtask

  initial begin
    rst_n = 0; issue_valid = 0; issue_ch = 0; done = 0; drain_req = 0; clr_peak = 0;
    repeat (2) @(posedge clk);
    #1;
    step(0, 0, 0, 2'b00, 0, 0);
    check("reset_all", 32'({stop, occupancy, peak, err_overflow, err_underflow, drain_done}), 32'd0);

    // 1: fill ch0 to 15
    issue(14, 0, 0);
    check("t1_stop_at14", 32'(stop), 32'd0);
    issue(1, 0, 0);
    check("t1_occ0", 32'(occupancy[4:0]), 32'd15);
    check("t1_stop", 32'(stop), 32'b01);

    // 2: hysteresis
    complete(1, 2'b01, 0);
    check("t2_stop_at14", 32'(stop), 32'b01);
    complete(1, 2'b01, 0);
    check("t2_stop_at13", 32'(stop), 32'b00);
    complete(1, 2'b01, 0);
    issue(2, 0, 0);
    check("t2_reissue14", 32'(stop), 32'b00);
    issue(1, 0, 0);
    check("t2_reissue15", 32'(stop), 32'b01);

    // 3: simultaneous events
    complete(10, 2'b01, 0);
    step(1, 1, 0, 2'b01, 0, 0);
    check("t3_same_ch", 32'(occupancy), 32'd5);
    step(1, 1, 1, 2'b01, 0, 0);
    check("t3_cross_ch", 32'(occupancy), 32'({5'd1, 5'd4}));
    complete(1, 2'b11, 0);
    complete(3, 2'b01, 0);

    // 4: saturation and underflow
    issue(17, 0, 0);
    check("t4_sat", 32'(occupancy[4:0]), 32'd16);
    check("t4_ovf", 32'(err_overflow), 32'b01);
    complete(1, 2'b10, 0);
    check("t4_unf", 32'(err_underflow), 32'b10);
    check("t4_ch1_zero", 32'(occupancy[9:5]), 32'd0);
    complete(16, 2'b01, 0);
    check("t4_ovf_sticky", 32'(err_overflow), 32'b01);

    // 5: drain
    issue(3, 0, 0);
    issue(2, 1, 0);
    idle(1, 1);
    check("t5_stop_all", 32'(stop), 32'b11);
    complete(2, 2'b11, 1);
    check("t5_not_done", 32'(drain_done), 32'd0);
    complete(1, 2'b01, 1);
    check("t5_done", 32'(drain_done), 32'd1);
    idle(1, 0);
    check("t5_release", 32'({stop, drain_done}), 32'd0);
    idle(1, 1);
    idle(1, 1);
    check("t5_empty_drain", 32'(drain_done), 32'd1);
    issue(1, 0, 1);
    check("t5_reenter_drain", 32'(drain_done), 32'd0);
    complete(1, 2'b01, 1);
    idle(1, 0);
    issue(1, 1, 1);
    idle(1, 0);
    check("t5_abort", 32'({stop, drain_done}), 32'd0);
    complete(1, 2'b10, 0);

    // 6: peak and mid-traffic reset
    step(1, 0, 0, 2'b00, 0, 1);
    issue(9, 1, 0);
    check("t6_peak9", 32'(peak[9:5]), 32'd9);
    complete(5, 2'b10, 0);
    step(1, 0, 0, 2'b00, 0, 1);
    check("t6_clr_peak", 32'(peak[9:5]), 32'd4);
    step(1, 1, 1, 2'b00, 0, 1);
    issue(3, 0, 0);
    step(0, 1, 0, 2'b01, 1, 0);
    check("t6_reset", 32'({stop, occupancy, peak, err_overflow, err_underflow, drain_done}), 32'd0);
    issue(2, 1, 0);
    idle(1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
